// File: rtl/axi_lite_slave_regs.sv
//------------------------------------------------------------------------------
// Module      : axi_lite_slave_regs
// Description : AXI4-Lite responder for a bank of 32-bit control registers with
//               byte strobes and per-register write pulses. Defining the macro
//               AXIL_SLAVE_SLVERR_EN makes out-of-range accesses return SLVERR.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_lite_slave_regs #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [32*NUM_REGS-1:0]    regs_o,
  output logic [NUM_REGS-1:0]       wr_pulse_o
);

  localparam int         c_idx_w     = ADDR_WIDTH - 2;
  localparam logic [1:0] c_resp_okay = 2'b00;
`ifdef AXIL_SLAVE_SLVERR_EN
  localparam logic [1:0] c_resp_oor  = 2'b10;
`else
  localparam logic [1:0] c_resp_oor  = 2'b00;
`endif

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_WRITE = 2'd1,
    W_RESP  = 2'd2
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic                r_aw_cap;
  logic                r_w_cap;
  logic [c_idx_w-1:0]  r_aw_idx;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [1:0]          r_bresp;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic [31:0]         r_regs [NUM_REGS];

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic [c_idx_w-1:0]  w_ar_idx;
  logic [NUM_REGS-1:0] w_aw_hit;
  logic [NUM_REGS-1:0] w_ar_hit;
  logic [31:0]         w_rd_mux;
  logic                w_aw_in_range;
  logic                w_ar_in_range;
  logic                w_unused_addr_bits;

  // Byte-offset bits carry no meaning for word-wide registers.
  assign w_unused_addr_bits = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign w_ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];

  // Readies come only from state and reset, never from the valids.
  assign s_axi_awready = !areset && (r_wstate == W_IDLE) && !r_aw_cap;
  assign s_axi_wready  = !areset && (r_wstate == W_IDLE) && !r_w_cap;
  assign s_axi_arready = !areset && (r_rstate == R_IDLE);

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;

  assign s_axi_bvalid = (r_wstate == W_RESP);
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rvalid = (r_rstate == R_DATA);
  assign s_axi_rdata  = r_rdata;
  assign s_axi_rresp  = r_rresp;

  // Address decode: a missing hit means the index is out of range.
  always_comb begin
    w_aw_hit = '0;
    w_ar_hit = '0;
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_aw_idx == c_idx_w'(i)) w_aw_hit[i] = 1'b1;
      if (w_ar_idx == c_idx_w'(i)) begin
        w_ar_hit[i] = 1'b1;
        w_rd_mux    = r_regs[i];
      end
    end
  end

  assign w_aw_in_range = |w_aw_hit;
  assign w_ar_in_range = |w_ar_hit;

  assign wr_pulse_o = (!areset && r_wstate == W_WRITE) ? w_aw_hit : '0;

  //--------------------------------------------------------------------------
  // Write channel
  //--------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if ((r_aw_cap || w_aw_hs) && (r_w_cap || w_w_hs)) w_wstate_nxt = W_WRITE;
      W_WRITE: w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_aw_cap <= 1'b0;
      r_w_cap  <= 1'b0;
      r_aw_idx <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= c_resp_okay;
    end else begin
      if (r_wstate == W_RESP && s_axi_bready) begin
        r_aw_cap <= 1'b0;
        r_w_cap  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_cap <= 1'b1;
          r_aw_idx <= s_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_w_hs) begin
          r_w_cap <= 1'b1;
          r_wdata <= s_axi_wdata;
          r_wstrb <= s_axi_wstrb;
        end
      end
      if (r_wstate == W_WRITE)
        r_bresp <= w_aw_in_range ? c_resp_okay : c_resp_oor;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_wstate == W_WRITE) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_aw_hit[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign regs_o[32*gi +: 32] = r_regs[gi];
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Read channel
  //--------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Sampling here sees the pre-commit value when a write lands on the same edge.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rdata <= '0;
      r_rresp <= c_resp_okay;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_mux;
      r_rresp <= w_ar_in_range ? c_resp_okay : c_resp_oor;
    end
  end

endmodule

`default_nettype wire

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite responder exposing a bank of 32-bit read/write control registers to the fabric side of the design. It is the far end of the AXI4-Lite master in this core: it accepts write and read transactions, applies byte strobes, returns responses, and drives the register contents plus per-register write pulses to downstream logic. It supports one outstanding write and one outstanding read, processed concurrently and independently.

## Interface
- NUM_REGS, 16, number of 32-bit registers (1..64)
- ADDR_WIDTH, 8, AXI address width; must satisfy 2^(ADDR_WIDTH-2) >= NUM_REGS

- aclk  in  1  clock; all logic on rising edge
- areset  in  1  reset; synchronous, active-high
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- regs_o  out  32*NUM_REGS  register contents, reg i at bits [32*i+31:32*i]
- wr_pulse_o  out  NUM_REGS  one-cycle pulse per register written

## Operation
- Decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored; in range iff index < NUM_REGS.
- Write FSM states W_IDLE, W_WRITE, W_RESP.
  - W_IDLE: awready = !aw_captured, wready = !w_captured; AW and W captured independently in any order or same edge.
  - Edge on which both are held: -> W_WRITE.
  - W_WRITE (1 cycle): wr_pulse_o[index]=1 if in range; at end of cycle bytes with wstrb[b]=1 update reg[index][8b+7:8b]; wstrb=0 still pulses, data unchanged. -> W_RESP.
  - W_RESP: bvalid=1, bresp held stable until bvalid&&bready edge -> W_IDLE, capture flags cleared.
- Read FSM states R_IDLE, R_DATA.
  - R_IDLE: arready=1; on arvalid&&arready edge, rdata latched from current reg[index] (pre-write value if a write updates it same edge), -> R_DATA.
  - R_DATA: arready=0, rvalid=1, rdata/rresp stable until rvalid&&rready edge -> R_IDLE.
- Out-of-range writes modify nothing and pulse nothing; out-of-range reads return rdata=0.
- bresp/rresp = 2'b00 (OKAY) for in-range access; out-of-range per Configuration.

## Timing
- Reset values (while areset high and first cycle after): all readies 0 during reset (gated by areset), bvalid=0, rvalid=0, bresp=rresp=0, rdata=0, regs_o=0, wr_pulse_o=0; both FSMs in IDLE.
- awready/wready/arready high in the first cycle after areset deasserts.
- Write latency: last AW/W handshake edge E0 -> wr_pulse_o high cycle E0+1 -> regs_o updated and bvalid high from E0+2.
- Back-to-back writes: awready/wready return high the cycle after B handshake; max throughput one write per 3 cycles.
- Read latency: AR handshake edge -> rvalid high next cycle; one read per 2 cycles with rready held high.
- Readies never depend combinationally on valids; valid outputs never drop without handshake except on reset.
- Reset mid-transaction: captured AW/W/AR discarded, bvalid/rvalid drop next cycle, registers cleared, no response issued.

## Configuration
- AXIL_SLAVE_SLVERR_EN defined: out-of-range write returns bresp=2'b10 (SLVERR); out-of-range read returns rresp=2'b10, rdata=0.
- Not defined: out-of-range accesses return OKAY (2'b00); write ignored, read data 0. Timing identical in both builds.

## Test plan
- Reset release, then write 0xDEADBEEF, wstrb=4'hF to addr 0x08 -> wr_pulse_o[2] one cycle, regs_o reg 2 = 0xDEADBEEF, bresp=OKAY; read 0x08 -> rdata=0xDEADBEEF.
- W presented 3 cycles before AW, bready low 4 cycles -> bvalid held 4 cycles with stable bresp, awready/wready low until B handshake.
- Reg 0 = 0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> reg 0 = 0x11BB33DD.
- Write addr 0x40 (index 16, NUM_REGS=16) -> no reg change, no pulse; bresp=2'b10 with macro, 2'b00 without; read 0x40 -> rdata=0.
- Read reg 3 on same edge as its write commit -> rdata = old value; subsequent read -> new value; concurrent read and write both complete.
- areset asserted while bvalid=1 and rvalid=1 -> both 0 next cycle, regs_o=0, readies 0 during reset, 1 cycle after release.
